// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// ------------------
// Drain engine for the read side of a dual-clock FIFO. It issues FIFO reads,
// absorbs the RAM's one-cycle read latency in a two-entry skid buffer, and
// presents the words as a valid/ready stream. Every BURST_LEN-th accepted beat
// is flagged with m_last so that downstream framing sees fixed-size bursts.
//
// Ports
//   clk          read-side clock (the FIFO rdclk)
//   rst          asynchronous active-high reset; buffered and in-flight words
//                are discarded (the FIFO itself is not reset, so those words
//                are lost)
//   enable       when low no new reads are issued; buffered words still drain
//   fifo_empty   FIFO empty flag (combinational from the FIFO)
//   fifo_rden    FIFO read enable (combinational)
//   fifo_rddata  FIFO read data, valid the cycle after fifo_rden was sampled
//   m_valid      stream word available
//   m_ready      downstream accepts
//   m_data       stream data (buffer head)
//   m_last       high with m_valid on the last beat of a burst
//   burst_cnt    completed bursts, wraps at 2^16
module fifo_stream_reader #(
  parameter int WIDTH     = 64,
  parameter int BURST_LEN = 16,
  parameter int CNT_BITS  = $clog2(BURST_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_rddata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      burst_cnt
);

  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

  logic [1:0]          r_occ;        // words held in the buffer (0..2)
  logic                r_inflight;   // a read was issued last cycle
  logic [WIDTH-1:0]    r_buf [2];    // entry 0 is the head
  logic [CNT_BITS-1:0] r_beat;
  logic [15:0]         r_burst_cnt;

  logic       w_pop;
  logic       w_last_beat;
  logic [1:0] w_occ_after_pop;
  logic [2:0] w_level;

  assign m_valid     = (r_occ != 2'd0);
  assign m_data      = r_buf[0];
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign m_last      = m_valid && w_last_beat;
  assign burst_cnt   = r_burst_cnt;

  assign w_pop           = m_valid && m_ready;
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};

  // Occupancy the buffer will have once this cycle's pop and the in-flight
  // word are both accounted for. Counting the pop here lets a read be issued
  // in the same cycle a word leaves, which is what sustains one word/cycle.
  assign w_level = {1'b0, w_occ_after_pop} + {2'b00, r_inflight};

  // Never read an empty FIFO: it would not advance and the RAM output would
  // be stale data that we would then present as a real word.
  assign fifo_rden = enable && !fifo_empty && !rst && (w_level < 3'd2);

  // Skid buffer. A pop shifts entry 1 into the head; a captured word lands in
  // the first free slot after the pop. Both may happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= fifo_rden;
      if (w_pop) begin
        r_buf[0] <= r_buf[1];
      end
      if (r_inflight) begin
        if (w_occ_after_pop == 2'd0) begin
          r_buf[0] <= fifo_rddata;
        end else begin
          r_buf[1] <= fifo_rddata;
        end
      end
      r_occ <= w_occ_after_pop + {1'b0, r_inflight};
    end
  end

  // Beat position within the burst; only accepted beats advance it, so stalls,
  // FIFO underruns and enable gaps never shift where m_last falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat      <= '0;
      r_burst_cnt <= 16'd0;
    end else if (w_pop) begin
      if (w_last_beat) begin
        r_beat      <= '0;
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end else begin
        r_beat <= r_beat + CNT_BITS'(1);
      end
    end
  end

`ifdef FORMAL
  // The read lookahead keeps occ + inflight within the two buffer slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_occ <= 2'd2);
      assert (!(r_occ == 2'd2 && r_inflight));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural FIFO model on the read side,
// scenario table plus hand-written enable and mid-operation reset sequences.
// Expected words are queued when written into the FIFO model and compared as
// the DUT hands them out; m_last and burst_cnt come from a beat model.
module tb_fifo_stream_reader;

  localparam int W  = 64;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [15:0]  burst_cnt;

  int checks   = 0;
  int failures = 0;

  // FIFO model: one-cycle registered read, never reset by the DUT.
  logic [W-1:0] mem [0:1023];
  int wr_ptr     = 0;
  int rd_ptr     = 0;
  int rden_count = 0;
  int rden_base  = 0;
  int pop_count  = 0;

  logic [W-1:0] exp_q [$];
  int           exp_beat   = 0;
  logic [15:0]  exp_bursts = 16'd0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  logic         stall_last = 1'b0;

  typedef struct {
    int n_pre;       // words preloaded before reset release
    int n_slow;      // words written by a writer at 2 words per 3 clocks
    int ready_mode;  // 0 always ready, 1 toggling, 2 low for 50 cycles
    int exp_first;   // cycle after release in which m_valid first rises
    int exp_rden;    // total read pulses
    int exp_bursts;  // burst_cnt at the end
  } vec_t;

  vec_t vecs [4];

  fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .burst_cnt   (burst_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rddata <= mem[rd_ptr % 1024];
      rd_ptr      <= rd_ptr + 1;
      rden_count  <= rden_count + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_beat   = 0;
      exp_bursts = 16'd0;
      stall_prev = 1'b0;
    end else begin
      check("burst_cnt", burst_cnt, exp_bursts);
      check("rden_while_empty", fifo_rden && fifo_empty, 0);
      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
        check("stall_last", m_last, stall_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_data, 64'hdead);
        end else begin
          logic [W-1:0] d;
          d = exp_q.pop_front();
          check("data", m_data, d);
          check("last", m_last, exp_beat == BL - 1);
        end
        pop_count++;
        if (exp_beat == BL - 1) begin
          exp_beat   = 0;
          exp_bursts = exp_bursts + 16'd1;
        end else begin
          exp_beat++;
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  // Reset the DUT, preload the FIFO, then release in "cycle 0".
  task automatic start(input int n, input int base, input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_burst_cnt", burst_cnt, 0);
    for (int i = 0; i < n; i++) push_word(W'(base + i));
    enable = 1'b1;
    #1;
    check("rst_rden_held_low", fifo_rden, 0);
    m_ready   = rdy;
    rden_base = rden_count;
    rst       = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_pops(input int n, input string name);
    int pb;
    bit ok;
    pb = pop_count;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (pop_count - pb >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pushed;
    bit done;
    int pa;

    vecs[0] = '{n_pre: 40, n_slow: 0,   ready_mode: 0, exp_first: 2, exp_rden: 40,  exp_bursts: 2};
    vecs[1] = '{n_pre: 40, n_slow: 0,   ready_mode: 1, exp_first: 2, exp_rden: 40,  exp_bursts: 2};
    vecs[2] = '{n_pre: 10, n_slow: 0,   ready_mode: 2, exp_first: 2, exp_rden: 10,  exp_bursts: 0};
    vecs[3] = '{n_pre: 0,  n_slow: 100, ready_mode: 0, exp_first: 3, exp_rden: 100, exp_bursts: 6};

    for (int s = 0; s < 4; s++) begin
      start(vecs[s].n_pre, s * 1000, vecs[s].ready_mode != 2);
      first  = -1;
      pushed = 0;
      done   = 1'b0;
      for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
        @(posedge clk); #1;
        if (first < 0 && m_valid) first = cyc;
        if (vecs[s].ready_mode == 2 && cyc == 50) begin
          // Stalled downstream: exactly two words pulled, head is word 0.
          check("stall_rden_pulses", rden_count - rden_base, 2);
          check("stall_head_valid", m_valid, 1);
          check("stall_head_data", m_data, exp_q[0]);
        end
        case (vecs[s].ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (cyc % 2 == 0);
          default: m_ready = (cyc >= 50);
        endcase
        if (pushed < vecs[s].n_slow && (cyc % 3) != 0) begin
          push_word(W'(s * 1000 + pushed));
          pushed++;
        end
        if (pushed == vecs[s].n_slow && exp_q.size() == 0 && !m_valid) done = 1'b1;
      end
      check("scn_completed", done, 1);
      check("scn_first_valid_cycle", first, vecs[s].exp_first);
      check("scn_rden_pulses", rden_count - rden_base, vecs[s].exp_rden);
      check("scn_burst_cnt", burst_cnt, vecs[s].exp_bursts);
      check("scn_words_left", exp_q.size(), 0);
      $display("scenario %0d: words=%0d first_valid=%0d rden=%0d bursts=%0d",
               s, vecs[s].n_pre + vecs[s].n_slow, first, rden_count - rden_base, burst_cnt);
    end

    // enable dropped right after word 5 is accepted. In steady streaming the
    // buffer holds word 6 and word 7 is in flight, so exactly those two drain.
    start(40, 5000, 1'b1);
    wait_pops(6, "en_wait_word5");
    enable = 1'b0;
    pa = pop_count;
    repeat (10) @(posedge clk);
    #1;
    check("en_off_extra_beats", pop_count - pa, 2);
    check("en_off_valid", m_valid, 0);
    check("en_off_rden_total", rden_count - rden_base, 8);
    check("en_off_next_word", exp_q[0], W'(5008));
    enable = 1'b1;
    drain("en_drain");
    check("en_burst_cnt", burst_cnt, 2);
    $display("enable sequence: extra beats after disable=2 expected, bursts=%0d", burst_cnt);

    // Asynchronous reset with the buffer full (occ=2) after one burst.
    start(40, 6000, 1'b1);
    wait_pops(20, "rst_wait_20");
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #3;
    check("pre_rst_burst_cnt", burst_cnt, 1);
    rst = 1'b1;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_m_last", m_last, 0);
    check("async_rst_m_data", m_data, 0);
    check("async_rst_burst_cnt", burst_cnt, 0);
    check("async_rst_rden", fifo_rden, 0);
    check("async_rst_words_read", rden_count - rden_base, 22);
    // Words already pulled from the FIFO are lost; the stream resumes at the
    // next word still in the FIFO.
    exp_q.delete();
    for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i % 1024]);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    drain("rst_drain");
    check("rst_resume_burst_cnt", burst_cnt, 1);
    check("rst_rden_total", rden_count - rden_base, 40);
    $display("reset sequence: resumed after words lost, bursts=%0d", burst_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
